// File: rtl/cpu_pkg.sv
// Shared definitions for the simple_cpu core.
// Contents: datapath width, opcode encoding, FSM state encoding and
// bus-source selector used by the top-level control logic.
package cpu_pkg;

  localparam int DATA_W = 16;

  // Opcodes live in IR[8:6]; values 3'b100..3'b111 are reserved and act as NOPs.
  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } op_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_RX   = 3'd1,
    SEL_RY   = 3'd2,
    SEL_DIN  = 3'd3,
    SEL_G    = 3'd4
  } bus_sel_e;

endpackage

// File: rtl/regn.sv
// Generic W-bit register with load enable and an optional asynchronous
// active-low clear. Used for R0-R7 (no clear) and for A, G, IR (cleared).
// Ports:
//   clk_i   in  1  clock, rising edge
//   rst_ni  in  1  asynchronous active-low clear (ignored when HAS_CLR=0)
//   ld_i    in  1  load enable
//   d_i     in  W  data to load
//   q_o     out W  register contents
module regn #(
  parameter int W       = 16,
  parameter bit HAS_CLR = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  generate
    if (HAS_CLR) begin : g_clr
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          q_q <= '0;
        end else if (ld_i) begin
          q_q <= d_i;
        end
      end
    end else begin : g_noclr
      // General-purpose registers keep their contents across reset.
      logic unused_rst;
      assign unused_rst = rst_ni;
      always_ff @(posedge clk_i) begin
        if (ld_i) begin
          q_q <= d_i;
        end
      end
    end
  endgenerate

  assign q_o = q_q;

endmodule

// File: rtl/simple_cpu.sv
// Multi-cycle 16-bit accumulator-style core: eight GPRs, A, G, IR and a
// single shared bus. Executes mv, mvi, add and sub, one per run handshake.
// Ports:
//   clock        in  1       rising-edge clock
//   resetn       in  1       asynchronous active-low reset
//   run          in  1       fetch request, sampled in T0
//   din          in  DATA_W  instruction word, or mvi immediate in T1
//   done         out 1       high during the last cycle of an instruction
//   bus          out DATA_W  current bus value
//   dbg_wr_en    in  1       GPR preload strobe (wins over FSM writes)
//   dbg_wr_sel   in  3       GPR index for preload
//   dbg_wr_data  in  DATA_W  preload value
//   dbg_rd_sel   in  3       GPR index to observe
//   dbg_rd_data  out DATA_W  combinational R[dbg_rd_sel]
module simple_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic              done,
  output logic [DATA_W-1:0] bus,
  input  logic              dbg_wr_en,
  input  logic [2:0]        dbg_wr_sel,
  input  logic [DATA_W-1:0] dbg_wr_data,
  input  logic [2:0]        dbg_rd_sel,
  output logic [DATA_W-1:0] dbg_rd_data
);

  state_e            state_q, state_d;
  logic [8:0]        ir_q;
  logic [DATA_W-1:0] a_q, g_q, g_d;
  logic [DATA_W-1:0] r_q [8];

  op_e        op;
  logic [2:0] rx, ry;
  logic       is_arith;
  bus_sel_e   sel;
  logic       ir_ld, a_ld, g_ld, rx_wr;

  assign op       = op_e'(ir_q[8:6]);
  assign rx       = ir_q[5:3];
  assign ry       = ir_q[2:0];
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      T0: if (run) state_d = T1;
      T1: state_d = is_arith ? T2 : T0;
      T2: state_d = T3;
      T3: state_d = T0;
    endcase
  end

  // Control outputs; reserved opcodes fall through to a bare done in T1.
  always_comb begin
    sel   = SEL_NONE;
    ir_ld = 1'b0;
    a_ld  = 1'b0;
    g_ld  = 1'b0;
    rx_wr = 1'b0;
    done  = 1'b0;
    case (state_q)
      T0: ir_ld = run;
      T1: begin
        case (op)
          OP_MV: begin
            sel   = SEL_RY;
            rx_wr = 1'b1;
            done  = 1'b1;
          end
          OP_MVI: begin
            sel   = SEL_DIN;
            rx_wr = 1'b1;
            done  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            sel  = SEL_RX;
            a_ld = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        sel  = SEL_RY;
        g_ld = 1'b1;
      end
      T3: begin
        sel   = SEL_G;
        rx_wr = 1'b1;
        done  = 1'b1;
      end
    endcase
  end

  // Shared bus: exactly one driver, zero when nothing is selected.
  always_comb begin
    case (sel)
      SEL_RX:  bus = r_q[rx];
      SEL_RY:  bus = r_q[ry];
      SEL_DIN: bus = din;
      SEL_G:   bus = g_q;
      default: bus = '0;
    endcase
  end

  // Modulo-2^DATA_W add/subtract, no flags.
  assign g_d = (op == OP_SUB) ? (a_q - bus) : (a_q + bus);

  regn #(.W(9), .HAS_CLR(1'b1)) u_ir (
    .clk_i(clock), .rst_ni(resetn), .ld_i(ir_ld), .d_i(din[8:0]), .q_o(ir_q)
  );

  regn #(.W(DATA_W), .HAS_CLR(1'b1)) u_a (
    .clk_i(clock), .rst_ni(resetn), .ld_i(a_ld), .d_i(bus), .q_o(a_q)
  );

  regn #(.W(DATA_W), .HAS_CLR(1'b1)) u_g (
    .clk_i(clock), .rst_ni(resetn), .ld_i(g_ld), .d_i(g_d), .q_o(g_q)
  );

  // GPR file: a debug preload overrides an FSM write to the same register.
  for (genvar k = 0; k < 8; k++) begin : g_gpr
    logic              dbg_hit, fsm_hit;
    logic [DATA_W-1:0] r_d;
    assign dbg_hit = dbg_wr_en && (dbg_wr_sel == 3'(k));
    assign fsm_hit = rx_wr && (rx == 3'(k));
    assign r_d     = dbg_hit ? dbg_wr_data : bus;
    regn #(.W(DATA_W), .HAS_CLR(1'b0)) u_r (
      .clk_i(clock), .rst_ni(resetn), .ld_i(dbg_hit || fsm_hit), .d_i(r_d), .q_o(r_q[k])
    );
  end

  assign dbg_rd_data = r_q[dbg_rd_sel];

endmodule

// File: tb/tb_simple_cpu.sv
module tb_simple_cpu;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         resetn, run, done, dbg_wr_en;
  logic [W-1:0] din, bus, dbg_wr_data, dbg_rd_data;
  logic [2:0]   dbg_wr_sel, dbg_rd_sel;

  int checks   = 0;
  int failures = 0;

  // Architectural model of the register file.
  logic [W-1:0] m [8];

  typedef struct {
    int           op;
    int           rx;
    int           ry;
    logic [W-1:0] imm;
    logic [W-1:0] exp_rx;
    int           lat;
  } vec_t;

  vec_t vecs [9];

  always #10 clock = ~clock;

  simple_cpu #(.DATA_W(W)) dut (
    .clock(clock), .resetn(resetn), .run(run), .din(din), .done(done), .bus(bus),
    .dbg_wr_en(dbg_wr_en), .dbg_wr_sel(dbg_wr_sel), .dbg_wr_data(dbg_wr_data),
    .dbg_rd_sel(dbg_rd_sel), .dbg_rd_data(dbg_rd_data)
  );

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] enc(input int op, input int rx, input int ry);
    return {7'b0, op[2:0], rx[2:0], ry[2:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 8; k++) begin
      dbg_rd_sel = 3'(k);
      #1;
      chk($sformatf("%s R%0d", tag, k), dbg_rd_data, m[k]);
    end
  endtask

  task automatic preload(input int k, input logic [W-1:0] v);
    run         = 1'b0;
    dbg_wr_en   = 1'b1;
    dbg_wr_sel  = 3'(k);
    dbg_wr_data = v;
    tick();
    dbg_wr_en   = 1'b0;
    m[k]        = v;
  endtask

  // Entered shortly after a rising edge with the core in T0.
  task automatic exec(input int op, input int rx, input int ry, input logic [W-1:0] imm,
                      input int lat, input bit run_after);
    logic [W-1:0] exp_bus;
    din = enc(op, rx, ry);
    run = 1'b1;
    #1;
    chk($sformatf("T0 done op%0d", op), W'(done), '0);
    tick();
    run = run_after;
    if (op == 1) din = imm;
    else         din = W'($urandom);
    #1;
    case (op)
      0:       exp_bus = m[ry];
      1:       exp_bus = imm;
      2, 3:    exp_bus = m[rx];
      default: exp_bus = '0;
    endcase
    chk($sformatf("T1 bus op%0d", op), bus, exp_bus);
    for (int c = 1; c < lat; c++) begin
      chk($sformatf("done c%0d op%0d", c, op), W'(done), W'(c == lat - 1));
      if (c == 2) chk("T2 bus", bus, m[ry]);
      if (c == 3) begin
        exp_bus = (op == 2) ? m[rx] + m[ry] : m[rx] - m[ry];
        chk("T3 bus", bus, exp_bus);
      end
      tick();
    end
    chk($sformatf("after done op%0d", op), W'(done), '0);
    case (op)
      0:       m[rx] = m[ry];
      1:       m[rx] = imm;
      2:       m[rx] = m[rx] + m[ry];
      3:       m[rx] = m[rx] - m[ry];
      default: ;
    endcase
    check_regs($sformatf("op%0d", op));
  endtask

  initial begin
    vecs = '{
      '{0, 0, 1, 16'h0000, 16'h0001, 2},
      '{1, 0, 0, 16'h000F, 16'h000F, 2},
      '{2, 2, 3, 16'h0000, 16'h0005, 4},
      '{3, 7, 6, 16'h0000, 16'h0001, 4},
      '{3, 0, 1, 16'h0000, 16'hFFFF, 4},
      '{2, 4, 4, 16'h0000, 16'h0008, 4},
      '{0, 5, 5, 16'h0000, 16'h0005, 2},
      '{7, 3, 1, 16'h0000, 16'h0003, 2},
      '{4, 6, 2, 16'h0000, 16'h0006, 2}
    };

    resetn = 1'b0; run = 1'b0; din = '0; dbg_wr_en = 1'b0;
    dbg_wr_sel = '0; dbg_wr_data = '0; dbg_rd_sel = '0;
    tick();
    chk("reset done", W'(done), '0);
    chk("reset bus", bus, '0);
    chk("reset state", W'(dut.state_q), '0);
    chk("reset ir", W'(dut.ir_q), '0);
    chk("reset A", dut.a_q, '0);
    chk("reset G", dut.g_q, '0);

    // Preload works while reset is held.
    for (int k = 0; k < 8; k++) preload(k, W'(k * 3 + 1));
    check_regs("preload in reset");
    resetn = 1'b1;
    tick();

    // Table vectors, each starting from Rk = k.
    foreach (vecs[i]) begin
      for (int k = 0; k < 8; k++) preload(k, W'(k));
      exec(vecs[i].op, vecs[i].rx, vecs[i].ry, vecs[i].imm, vecs[i].lat, 1'b0);
      dbg_rd_sel = 3'(vecs[i].rx);
      #1;
      chk($sformatf("vec%0d result", i), dbg_rd_data, vecs[i].exp_rx);
      run = 1'b0;
      tick();
    end

    // Reset during T2 of add R2,R3.
    for (int k = 0; k < 8; k++) preload(k, W'(k));
    din = enc(2, 2, 3);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    resetn = 1'b0;
    #1;
    chk("midreset done", W'(done), '0);
    chk("midreset bus", bus, '0);
    chk("midreset state", W'(dut.state_q), '0);
    chk("midreset A", dut.a_q, '0);
    chk("midreset G", dut.g_q, '0);
    tick();
    check_regs("midreset");
    resetn = 1'b1;
    tick();
    exec(0, 4, 2, '0, 2, 1'b0);

    // Idle with run low: nothing moves.
    run = 1'b0;
    din = enc(0, 1, 2);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle done", W'(done), '0);
      chk("idle state", W'(dut.state_q), '0);
    end
    check_regs("idle");

    // Debug write beats an FSM write to the same register.
    din = enc(0, 1, 2);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("prio done", W'(done), 16'h0001);
    dbg_wr_en = 1'b1; dbg_wr_sel = 3'd1; dbg_wr_data = 16'hABCD;
    tick();
    dbg_wr_en = 1'b0;
    m[1] = 16'hABCD;
    check_regs("priority");

    // Back-to-back with run held high.
    exec(0, 3, 1, '0, 2, 1'b1);
    exec(1, 6, 0, 16'h1234, 2, 1'b1);
    exec(2, 6, 3, '0, 4, 1'b1);
    exec(3, 0, 6, '0, 4, 1'b1);

    // Randomized instruction stream against the model.
    for (int n = 0; n < 60; n++) begin
      int op, rx, ry;
      if ($urandom_range(0, 3) == 0) preload($urandom_range(0, 7), W'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        run = 1'b0;
        tick();
        chk("rand idle done", W'(done), '0);
      end
      op = $urandom_range(0, 7);
      rx = $urandom_range(0, 7);
      ry = $urandom_range(0, 7);
      exec(op, rx, ry, W'($urandom), (op == 2 || op == 3) ? 4 : 2, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
